// File: rtl/axilite_master_q.sv
// Queued AXI4-Lite master: user commands are buffered in a small FIFO and
// issued to the bus one transaction at a time.

// Generic synchronous FIFO with occupancy counter.
// Latency: one cycle from push to pop_vld.
// Backpressure: push_rdy low when full; a push while full is dropped even if a pop happens that cycle.
module axilite_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             push_en, pop_en;

    assign push_rdy = (count != (PW+1)'(DEPTH));
    assign pop_vld  = (count != '0);
    assign push_en  = push_vld && push_rdy;
    assign pop_en   = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_ptr];

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_en) mem[wr_ptr] <= push_dat;
    end
endmodule

// AXI4-Lite master fed from a command FIFO, one transaction outstanding.
// Latency: 4 cycles push-to-completion pulse with a zero-wait slave.
// Backpressure: user_free drops when the FIFO is full; AXI stalls hold VALIDs and payload.
module axilite_master_q #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int STRB_W  = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              user_start,
    input  logic              user_w_r,
    input  logic [ADDR_W-1:0] user_addr_in,
    input  logic [DATA_W-1:0] user_data_in,
    input  logic [STRB_W-1:0] user_data_strb,
    output logic              user_free,
    output logic [1:0]        user_status,
    output logic [DATA_W-1:0] user_data_out,
    output logic              user_data_out_valid,
    output logic              user_wr_done,
    output logic              user_timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    typedef struct packed {
        logic              w_r;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

    localparam int             TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_VAL = TW'(TIMEOUT);

    state_t            state, state_nxt;
    cmd_t              push_cmd, head;
    logic              fifo_vld, fifo_pop;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [STRB_W-1:0] cur_strb;
    logic              aw_pend, w_pend;
    logic [TW-1:0]     cnt;

    assign push_cmd = '{w_r: user_w_r, addr: user_addr_in, data: user_data_in, strb: user_data_strb};
    assign fifo_pop = (state == IDLE) && fifo_vld;

    axilite_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push_vld (user_start),
        .push_dat (push_cmd),
        .push_rdy (user_free),
        .pop_rdy  (fifo_pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (head)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (fifo_vld) state_nxt = head.w_r ? RD_ADDR : WR_ADDR_DATA;
            WR_ADDR_DATA: if ((!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready))
                              state_nxt = WR_RESP;
            WR_RESP:      if (m_axi_bvalid)  state_nxt = IDLE;
            RD_ADDR:      if (m_axi_arready) state_nxt = RD_DATA;
            RD_DATA:      if (m_axi_rvalid)  state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // Write address and data channels retire independently
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_addr            <= '0;
            cur_data            <= '0;
            cur_strb            <= '0;
            aw_pend             <= 1'b0;
            w_pend              <= 1'b0;
            cnt                 <= '0;
            user_status         <= 2'b00;
            user_data_out       <= '0;
            user_wr_done        <= 1'b0;
            user_data_out_valid <= 1'b0;
        end else begin
            if (fifo_pop) begin
                cur_addr <= head.addr;
                cur_data <= head.data;
                cur_strb <= head.strb;
                aw_pend  <= !head.w_r;
                w_pend   <= !head.w_r;
            end else begin
                aw_pend <= aw_pend && !m_axi_awready;
                w_pend  <= w_pend && !m_axi_wready;
            end

            if (state == IDLE)     cnt <= '0;
            else if (cnt != TO_VAL) cnt <= cnt + TW'(1);

            user_wr_done        <= (state == WR_RESP) && m_axi_bvalid;
            user_data_out_valid <= (state == RD_DATA) && m_axi_rvalid;
            if ((state == WR_RESP) && m_axi_bvalid) user_status <= m_axi_bresp;
            if ((state == RD_DATA) && m_axi_rvalid) begin
                user_status   <= m_axi_rresp;
                user_data_out <= m_axi_rdata;
            end
        end
    end

    assign user_timeout  = (state != IDLE) && (cnt == TO_VAL);
    assign m_axi_awaddr  = cur_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = aw_pend;
    assign m_axi_wdata   = cur_data;
    assign m_axi_wstrb   = cur_strb;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_araddr  = cur_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_DATA);
endmodule

// File: tb/tb_axilite_master_q.sv
// Bench for axilite_master_q: responding AXI4-Lite slave, in-order completion model.
module tb_axilite_master_q;
    localparam int ADDR_W = 32, DATA_W = 64, STRB_W = 8, DEPTH = 4, TIMEOUT = 1024;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic              user_start = 0, user_w_r = 0;
    logic [ADDR_W-1:0] user_addr_in = '0;
    logic [DATA_W-1:0] user_data_in = '0;
    logic [STRB_W-1:0] user_data_strb = '0;
    logic              user_free, user_data_out_valid, user_wr_done, user_timeout;
    logic [1:0]        user_status;
    logic [DATA_W-1:0] user_data_out;
    logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]        m_axi_awprot, m_axi_arprot;
    logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
    logic [STRB_W-1:0] m_axi_wstrb;
    logic [1:0]        m_axi_bresp, m_axi_rresp;
    logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic              m_axi_rvalid, m_axi_rready;

    axilite_master_q #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .aresetn(aresetn), .user_start(user_start), .user_w_r(user_w_r),
        .user_addr_in(user_addr_in), .user_data_in(user_data_in), .user_data_strb(user_data_strb),
        .user_free(user_free), .user_status(user_status), .user_data_out(user_data_out),
        .user_data_out_valid(user_data_out_valid), .user_wr_done(user_wr_done),
        .user_timeout(user_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Slave: memory of 256 words (addr[10:3]), response code taken from addr[5:4]
    logic        aw_hold = 0, b_hold = 0;
    int          w_delay = 0, r_delay = 0;
    logic [63:0] mem [256];
    logic        have_aw, have_w, aw_seen, r_pend;
    int          w_cnt, r_cnt;
    logic [31:0] waddr_l, raddr_l;
    logic [63:0] wdata_l;
    logic [7:0]  wstrb_l;
    logic        aw_now, w_now, ar_now, wr_fire;
    logic [31:0] waddr_eff;
    logic [63:0] wdata_eff;
    logic [7:0]  wstrb_eff;

    assign m_axi_awready = !aw_hold;
    assign m_axi_arready = 1'b1;
    assign m_axi_wready  = (w_delay == 0) ? 1'b1 : (aw_seen && w_cnt == 0);
    assign aw_now    = m_axi_awvalid && m_axi_awready;
    assign w_now     = m_axi_wvalid && m_axi_wready;
    assign ar_now    = m_axi_arvalid && m_axi_arready;
    assign waddr_eff = have_aw ? waddr_l : m_axi_awaddr;
    assign wdata_eff = have_w ? wdata_l : m_axi_wdata;
    assign wstrb_eff = have_w ? wstrb_l : m_axi_wstrb;
    assign wr_fire   = (have_aw || aw_now) && (have_w || w_now) && !m_axi_bvalid && !b_hold;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            have_aw <= 0; have_w <= 0; aw_seen <= 0; w_cnt <= 0; r_pend <= 0; r_cnt <= 0;
            m_axi_bvalid <= 0; m_axi_bresp <= 0; m_axi_rvalid <= 0; m_axi_rdata <= 0;
            m_axi_rresp <= 0; waddr_l <= 0; raddr_l <= 0; wdata_l <= 0; wstrb_l <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (aw_now) begin
                waddr_l <= m_axi_awaddr; have_aw <= 1; aw_seen <= 1; w_cnt <= w_delay;
            end else if (w_cnt != 0) w_cnt <= w_cnt - 1;
            if (w_now) begin
                wdata_l <= m_axi_wdata; wstrb_l <= m_axi_wstrb; have_w <= 1; aw_seen <= 0;
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 0;
            if (wr_fire) begin
                mem[waddr_eff[10:3]] <= merge(mem[waddr_eff[10:3]], wdata_eff, wstrb_eff);
                m_axi_bvalid <= 1; m_axi_bresp <= waddr_eff[5:4];
                have_aw <= 0; have_w <= 0;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
            if (ar_now) begin
                if (r_delay == 0) begin
                    m_axi_rvalid <= 1; m_axi_rdata <= mem[m_axi_araddr[10:3]];
                    m_axi_rresp <= m_axi_araddr[5:4];
                end else begin
                    r_pend <= 1; r_cnt <= r_delay; raddr_l <= m_axi_araddr;
                end
            end else if (r_pend) begin
                if (r_cnt == 1) begin
                    m_axi_rvalid <= 1; m_axi_rdata <= mem[raddr_l[10:3]];
                    m_axi_rresp <= raddr_l[5:4]; r_pend <= 0;
                end else r_cnt <= r_cnt - 1;
            end
        end
    end

    typedef struct {
        bit          rd;
        logic [63:0] data;
        logic [1:0]  status;
    } cmpl_t;

    cmpl_t       exp_q[$], obs_q[$];
    logic [63:0] model_mem [256];
    int          b_hs = 0, proto_err = 0;
    int          n_asserts = 0, n_fail = 0;

    // Completion monitor and handshake rule watcher
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_araddr;
    logic [63:0] p_wdata;
    logic [7:0]  p_wstrb;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (user_wr_done)        obs_q.push_back('{0, 64'h0, user_status});
            if (user_data_out_valid) obs_q.push_back('{1, user_data_out, user_status});
            if (m_axi_bvalid && m_axi_bready) b_hs <= b_hs + 1;
            if ((p_awv && !p_awr && !(m_axi_awvalid && m_axi_awaddr == p_awaddr)) ||
                (p_wv && !p_wr && !(m_axi_wvalid && m_axi_wdata == p_wdata && m_axi_wstrb == p_wstrb)) ||
                (p_arv && !p_arr && !(m_axi_arvalid && m_axi_araddr == p_araddr)) ||
                m_axi_awprot != 3'b000 || m_axi_arprot != 3'b000)
                proto_err <= proto_err + 1;
        end
        p_awv <= aresetn && m_axi_awvalid; p_awr <= m_axi_awready; p_awaddr <= m_axi_awaddr;
        p_wv  <= aresetn && m_axi_wvalid;  p_wr  <= m_axi_wready;  p_wdata  <= m_axi_wdata;
        p_wstrb <= m_axi_wstrb;
        p_arv <= aresetn && m_axi_arvalid; p_arr <= m_axi_arready; p_araddr <= m_axi_araddr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic rd, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] s, input bit accept);
        cmpl_t e;
        user_start = 1; user_w_r = rd; user_addr_in = a; user_data_in = d; user_data_strb = s;
        if (accept) begin
            e.rd = rd; e.status = a[5:4]; e.data = '0;
            if (rd) e.data = model_mem[a[10:3]];
            else    model_mem[a[10:3]] = merge(model_mem[a[10:3]], d, s);
            exp_q.push_back(e);
        end
        @(negedge aclk);
        user_start = 0;
    endtask

    task automatic drain(input string tag);
        int    waited;
        cmpl_t o, e;
        waited = 0;
        while (obs_q.size() < exp_q.size() && waited < 3000) begin
            @(negedge aclk); waited++;
        end
        repeat (4) @(negedge aclk);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            check({tag, "_kind"}, o.rd, e.rd);
            check({tag, "_status"}, o.status, e.status);
            if (e.rd) check({tag, "_rdata"}, o.data, e.data);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_free"}, user_free, 1);
        check({tag, "_status"}, user_status, 0);
        check({tag, "_dout"}, user_data_out, 0);
        check({tag, "_pulses"}, {user_data_out_valid, user_wr_done, user_timeout}, 0);
        check({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check({tag, "_readies"}, {m_axi_bready, m_axi_rready}, 0);
    endtask

    initial begin
        int k, lat, first_to, outstanding;
        logic last_to;
        logic [31:0] a;

        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        aresetn = 1;
        @(negedge aclk);

        // Write then readback, with push-to-completion latency
        push(0, 32'h1000_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1);
        lat = 1;
        while (!user_wr_done && lat < 50) begin @(negedge aclk); lat++; end
        check("wr_latency", lat, 4);
        push(1, 32'h1000_0000, 64'h0, 8'h00, 1);
        drain("wr_rd");
        check("wr_rd_data", user_data_out, 64'hDEAD_BEEF_DEAD_BEEF);
        check("wr_rd_status", user_status, 2'b00);

        // Partial strobe write over all-ones
        push(0, 32'h1000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1);
        push(0, 32'h1000_0008, 64'h1111_1111_2222_2222, 8'h0F, 1);
        push(1, 32'h1000_0008, 64'h0, 8'hFF, 1);
        drain("strb");
        check("strb_data", user_data_out, 64'hFFFF_FFFF_2222_2222);

        // Write data lags the address handshake
        w_delay = 3;
        k = b_hs;
        push(0, 32'h0000_0010, 64'h0123_4567_89AB_CDEF, 8'hF0, 1);
        lat = 0;
        while (!(m_axi_awvalid && m_axi_awready) && lat < 20) begin @(negedge aclk); lat++; end
        check("wdly_aw_seen", lat < 20, 1);
        @(negedge aclk);
        check("wdly_aw_dropped", m_axi_awvalid, 0);
        check("wdly_w_held", {m_axi_wvalid, m_axi_wready}, 2'b10);
        drain("wdly");
        check("wdly_one_b", b_hs - k, 1);
        w_delay = 0;

        // Fill the FIFO behind a stalled write
        aw_hold = 1;
        push(0, 32'h0000_0040, 64'hA5A5_0000_0000_5A5A, 8'hFF, 1);
        repeat (3) @(negedge aclk);
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("fill_free", user_free, i < DEPTH);
            a = 32'h48 + 32'(i * 8);
            push(i[0], a, {$urandom, $urandom}, 8'hFF, i < DEPTH);
        end
        check("fill_full", user_free, 0);
        check("fill_stalled", obs_q.size(), 0);
        // Held start while full must not sneak in on the pop edge
        user_start = 1; user_w_r = 1; user_addr_in = 32'h88;
        aw_hold = 0;
        k = 0;
        while (!user_free && k < 200) begin @(negedge aclk); k++; end
        user_start = 0;
        drain("fill");

        // Long read crosses the timeout threshold
        r_delay = 1100;
        push(1, 32'h0000_0018, 64'h0, 8'h00, 1);
        lat = 0;
        while (!m_axi_arvalid && lat < 20) begin @(negedge aclk); lat++; end
        first_to = -1; k = 0; last_to = 0;
        while (!user_data_out_valid && k < 3000) begin
            if (user_timeout && first_to < 0) first_to = k;
            last_to = user_timeout;
            @(negedge aclk); k++;
        end
        check("to_rise_cycle", first_to, TIMEOUT);
        check("to_held", last_to, 1);
        check("to_clear", user_timeout, 0);
        drain("to");
        r_delay = 0;

        // Random traffic, never more than DEPTH in flight
        for (int n = 0; n < 40; n++) begin
            outstanding = exp_q.size() - obs_q.size();
            while (outstanding >= DEPTH) begin
                @(negedge aclk); outstanding = exp_q.size() - obs_q.size();
            end
            w_delay = $urandom_range(0, 2);
            r_delay = $urandom_range(0, 3);
            check("rnd_free", user_free, 1);
            a = {21'h0, 4'($urandom_range(0, 15)), 3'b000};
            push($urandom_range(0, 1), a, {$urandom, $urandom}, 8'($urandom), 1);
            repeat ($urandom_range(0, 3)) @(negedge aclk);
        end
        drain("rnd");
        w_delay = 0; r_delay = 0;

        // Leave non-reset values on the user outputs, then reset in WR_RESP
        push(0, 32'h38, 64'hCAFE_F00D_1234_5678, 8'hFF, 1);
        push(1, 32'h38, 64'h0, 8'h00, 1);
        drain("prerst");
        b_hold = 1;
        push(0, 32'h20, 64'h1, 8'hFF, 1);
        push(0, 32'h28, 64'h2, 8'hFF, 1);
        push(1, 32'h20, 64'h0, 8'h00, 1);
        k = 0;
        while (!m_axi_bready && k < 50) begin @(negedge aclk); k++; end
        check("rst_in_wresp", m_axi_bready, 1);
        #2 aresetn = 0;
        #1 check_reset_outputs("rst_mid");
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        @(negedge aclk);
        aresetn = 1; b_hold = 0;
        repeat (20) @(negedge aclk);
        check("rst_no_cmpl", obs_q.size(), 0);
        check("rst_idle", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid}, 0);
        check("rst_free", user_free, 1);

        check("protocol", proto_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
